puzzle_move_ctrl: RTL and testbench
===================================

# puzzle_move_ctrl

Move sequencer for the 2x3 sliding-puzzle board held in the board register file. It accepts one move command at a time, reads the board, move count and move log, and checks the move against the blank position. A legal move is written back as an updated board, an incremented count and an extended log; an illegal one is rejected without writes. It is the register file's only writer and sits between the input/command logic and the register file.

## Interface
- No parameters. Board layout fixed: cell i (0..5) at bits [17-3i:15-3i]; row 0 = cells 0,1,2, row 1 = cells 3,4,5; tile 0 = blank.
- Register map fixed: reg 0 = board, reg 1 = move count, reg 2 = move log.
- clk  in  1  clock; one clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset; top ties register file rst_n = ~rst
- mv_valid  in  1  move command valid
- mv_dir  in  2  blank direction: 0 up, 1 down, 2 left, 3 right
- mv_ready  out  1  controller idle, command accepted when mv_valid & mv_ready
- rf_src0  out  4  register file read address 0
- rf_src1  out  4  register file read address 1
- rf_data0  in  18  combinational read data for rf_src0
- rf_data1  in  18  combinational read data for rf_src1
- rf_we  out  1  register file write enable
- rf_dst  out  4  write address
- rf_wdata  out  18  write data
- done  out  1  one-cycle pulse, command finished
- illegal  out  1  valid with done: command rejected
- solved  out  1  registered: last evaluated board == 18'h0A728 (1,2,3,4,5,0)

## Operation
- FSM states: IDLE, RD0, RD1, CALC, WB, WC, WO, DONE.
- IDLE: mv_ready=1. On accept, latch mv_dir and go to RD0.
- RD0: src0=0, src1=1; latch board and cnt; go to RD1.
- RD1: src0=2; latch ord; find blank pos p = lowest cell index with value 0; go to CALC.
- CALC: legality check.
  - up needs p>=3, partner p-3.
  - down needs p<=2, partner p+3.
  - left needs p not in {0,3}, partner p-1.
  - right needs p not in {2,5}, partner p+1.
  - No zero cell: illegal.
  - Legal: new board = board with cells p and partner swapped; go to WB.
  - Illegal: set illegal flag; go to DONE.
  - In both cases, update solved from the resulting board (the unchanged board when illegal).
- WB: we=1, dst=0, wdata=new board.
- WC: we=1, dst=1, wdata=cnt+1, saturating at 18'h3FFFF.
- WO: we=1, dst=2, wdata={ord[15:0], dir} (2-bit shift log, oldest bits drop).
- DONE: done=1, illegal valid; then IDLE.
- rf_we=0 in every other state. src/dst/wdata=0 when not used.
- Commands presented while mv_ready=0 are ignored and not queued. Holding mv_valid high is allowed.

## Timing
- Accept edge = E0. Legal: writes land at E4 (board), E5 (count), E6 (log). done is high in the cycle after E6, and mv_ready returns one cycle later. Accept-to-accept minimum is 8 cycles.
- Illegal: done is high in the cycle after E3; no write cycles occur.
- Reset values while rst is high and after it: state IDLE, mv_ready=0 during rst then 1, rf_we=0, rf_src0/rf_src1/rf_dst=0, rf_wdata=0, done=0, illegal=0, solved=0.
- rst mid-command: IDLE at the next edge, no further writes. Writes already committed stay, so board may be updated without count/log; this is accepted.
- solved changes only on the CALC edge.

## Test plan
- Reset, board 18'h0A728; mv_dir=0 (up) -> board 18'h0A12B (1,2,0,4,5,3), cnt=1, ord=0, illegal=0, solved=0; done 7 cycles after accept.
- Next, mv_dir=1 (down) -> board 18'h0A728, cnt=2, ord=18'h00001, solved=1.
- From 18'h0A728, mv_dir=3 (right, p=5) -> done with illegal=1, rf_we never asserted, cnt stays 0, solved=1.
- From 18'h0A728, mv_dir=2 (left) -> board 18'h0A705, ord low bits 2'b10.
- Preload cnt=18'h3FFFF; legal move -> cnt stays 18'h3FFFF; 10 legal moves -> ord holds the last 9 directions.
- Assert rst in WC cycle -> no count/log write, mv_ready=1 after rst drops, done never pulses; mv_valid held high during busy -> exactly one command accepted.

Source files
------------

// File: rtl/puzzle_move_ctrl_if.sv
// Command and register-file bus between the move sequencer and its neighbours.
// The master side is the sequencer; the slave side is the command source and the board register file.
interface puzzle_move_ctrl_if;
  logic        mv_valid;
  logic [1:0]  mv_dir;
  logic        mv_ready;
  logic [3:0]  rf_src0;
  logic [3:0]  rf_src1;
  logic [17:0] rf_data0;
  logic [17:0] rf_data1;
  logic        rf_we;
  logic [3:0]  rf_dst;
  logic [17:0] rf_wdata;
  logic        done;
  logic        illegal;
  logic        solved;

  modport master (
    input  mv_valid, mv_dir, rf_data0, rf_data1,
    output mv_ready, rf_src0, rf_src1, rf_we, rf_dst, rf_wdata, done, illegal, solved
  );

  modport slave (
    output mv_valid, mv_dir, rf_data0, rf_data1,
    input  mv_ready, rf_src0, rf_src1, rf_we, rf_dst, rf_wdata, done, illegal, solved
  );
endinterface

// File: rtl/puzzle_move_ctrl.sv
// Move sequencer for the 2x3 sliding puzzle: reads board/count/log, checks the move
// against the blank cell, and writes back board, saturating count and 2-bit direction log.
module puzzle_move_ctrl (
  input  logic                clk,
  input  logic                rst,
  puzzle_move_ctrl_if.master  bus
);

  localparam int unsigned BOARD_W = 18;
  localparam int unsigned CELL_W  = 3;
  localparam int unsigned NCELL   = 6;
  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned ORD_W   = 16;
  localparam logic [BOARD_W-1:0] SOLVED_BOARD = 18'h0A728;
  localparam logic [BOARD_W-1:0] CNT_MAX      = 18'h3FFFF;
  localparam logic [ADDR_W-1:0]  REG_BOARD    = 4'd0;
  localparam logic [ADDR_W-1:0]  REG_CNT      = 4'd1;
  localparam logic [ADDR_W-1:0]  REG_ORD      = 4'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_RD0, S_RD1, S_CALC, S_WB, S_WC, S_WO, S_DONE
  } state_t;

  state_t              r_state;
  logic [1:0]          r_dir;
  logic [BOARD_W-1:0]  r_board;
  logic [BOARD_W-1:0]  r_cnt;
  logic [ORD_W-1:0]    r_ord;
  logic [2:0]          r_pos;
  logic                r_found;
  logic                r_ready;
  logic [ADDR_W-1:0]   r_src0;
  logic [ADDR_W-1:0]   r_src1;
  logic                r_we;
  logic [ADDR_W-1:0]   r_dst;
  logic [BOARD_W-1:0]  r_wdata;
  logic                r_done;
  logic                r_illegal;
  logic                r_solved;

  logic [2:0]          w_pos;
  logic                w_found;
  logic                w_legal;
  logic [2:0]          w_partner;
  logic [BOARD_W-1:0]  w_new_board;
  logic [BOARD_W-1:0]  w_cnt_inc;

  // Cell 0 occupies the top bits of the board word.
  function automatic logic [CELL_W-1:0] cell_get(input logic [BOARD_W-1:0] b,
                                                 input int unsigned idx);
    int unsigned sh;
    sh = (NCELL - 1 - idx) * CELL_W;
    return CELL_W'(b >> sh);
  endfunction

  function automatic logic [BOARD_W-1:0] cell_set(input logic [BOARD_W-1:0] b,
                                                  input int unsigned idx,
                                                  input logic [CELL_W-1:0] v);
    int unsigned sh;
    sh = (NCELL - 1 - idx) * CELL_W;
    return (b & ~(BOARD_W'(3'b111) << sh)) | (BOARD_W'(v) << sh);
  endfunction

  // Lowest-index blank cell of the latched board.
  always_comb begin
    w_pos   = 3'd0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < NCELL; i++) begin
      if (!w_found && cell_get(r_board, i) == 3'd0) begin
        w_found = 1'b1;
        w_pos   = 3'(i);
      end
    end
  end

  // Legality and swap partner for the latched direction.
  always_comb begin
    w_legal   = 1'b0;
    w_partner = 3'd0;
    case (r_dir)
      2'd0: begin w_legal = (r_pos >= 3'd3);                     w_partner = r_pos - 3'd3; end
      2'd1: begin w_legal = (r_pos <= 3'd2);                     w_partner = r_pos + 3'd3; end
      2'd2: begin w_legal = (r_pos != 3'd0) && (r_pos != 3'd3);  w_partner = r_pos - 3'd1; end
      default: begin w_legal = (r_pos != 3'd2) && (r_pos != 3'd5); w_partner = r_pos + 3'd1; end
    endcase
    w_legal = w_legal && r_found;
  end

  always_comb begin
    w_new_board = cell_set(r_board, 32'(r_pos), cell_get(r_board, 32'(w_partner)));
    w_new_board = cell_set(w_new_board, 32'(w_partner), cell_get(r_board, 32'(r_pos)));
  end

  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 18'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_dir     <= 2'd0;
      r_board   <= '0;
      r_cnt     <= '0;
      r_ord     <= '0;
      r_pos     <= 3'd0;
      r_found   <= 1'b0;
      r_ready   <= 1'b0;
      r_src0    <= '0;
      r_src1    <= '0;
      r_we      <= 1'b0;
      r_dst     <= '0;
      r_wdata   <= '0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      r_solved  <= 1'b0;
    end else begin
      r_ready   <= 1'b0;
      r_src0    <= '0;
      r_src1    <= '0;
      r_we      <= 1'b0;
      r_dst     <= '0;
      r_wdata   <= '0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_ready && bus.mv_valid) begin
            r_dir   <= bus.mv_dir;
            r_src0  <= REG_BOARD;
            r_src1  <= REG_CNT;
            r_state <= S_RD0;
          end else begin
            r_ready <= 1'b1;
          end
        end
        S_RD0: begin
          r_board <= bus.rf_data0;
          r_cnt   <= bus.rf_data1;
          r_src0  <= REG_ORD;
          r_state <= S_RD1;
        end
        S_RD1: begin
          r_ord   <= bus.rf_data0[ORD_W-1:0];
          r_pos   <= w_pos;
          r_found <= w_found;
          r_state <= S_CALC;
        end
        S_CALC: begin
          if (w_legal) begin
            r_solved <= (w_new_board == SOLVED_BOARD);
            r_we     <= 1'b1;
            r_dst    <= REG_BOARD;
            r_wdata  <= w_new_board;
            r_state  <= S_WB;
          end else begin
            r_solved  <= (r_board == SOLVED_BOARD);
            r_done    <= 1'b1;
            r_illegal <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_WB: begin
          r_we    <= 1'b1;
          r_dst   <= REG_CNT;
          r_wdata <= w_cnt_inc;
          r_state <= S_WC;
        end
        S_WC: begin
          r_we    <= 1'b1;
          r_dst   <= REG_ORD;
          r_wdata <= {r_ord, r_dir};
          r_state <= S_WO;
        end
        S_WO: begin
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mv_ready = r_ready;
  assign bus.rf_src0  = r_src0;
  assign bus.rf_src1  = r_src1;
  assign bus.rf_we    = r_we;
  assign bus.rf_dst   = r_dst;
  assign bus.rf_wdata = r_wdata;
  assign bus.done     = r_done;
  assign bus.illegal  = r_illegal;
  assign bus.solved   = r_solved;

endmodule

// File: tb/tb_puzzle_move_ctrl.sv
// Bench for puzzle_move_ctrl: register file model, vector table and scoreboard of
// expected results checked whenever the sequencer pulses done.
module tb_puzzle_move_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  puzzle_move_ctrl_if bus();

  puzzle_move_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Register file model with a bench-side preload port.
  logic [17:0] rf [0:15];
  logic        pl_en;
  logic [3:0]  pl_addr;
  logic [17:0] pl_data;

  assign bus.rf_data0 = rf[bus.rf_src0];
  assign bus.rf_data1 = rf[bus.rf_src1];

  always @(posedge clk) begin
    if (pl_en) rf[pl_addr] <= pl_data;
    else if (bus.rf_we && !rst) rf[bus.rf_dst] <= bus.rf_wdata;
  end

  typedef struct {
    logic [17:0] board; logic [17:0] cnt; logic [17:0] ord; logic [1:0] dir;
    logic [17:0] e_board; logic [17:0] e_cnt; logic [17:0] e_ord; logic e_ill; logic e_sol;
  } vec_t;

  typedef struct {
    logic [17:0] board; logic [17:0] cnt; logic [17:0] ord;
    logic ill; logic sol; int lat; int writes;
  } exp_t;

  exp_t sbq[$];
  exp_t cur;
  vec_t vt [12];

  int errors = 0;
  int checks = 0;
  int lat = 0;
  int wr_cnt = 0;
  int acc_cnt = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!rst && bus.mv_valid && bus.mv_ready) begin
      acc_cnt++;
      lat = 0;
      wr_cnt = 0;
    end
  end

  // Scoreboard: every done pulse pops one expected result.
  always @(negedge clk) begin
    lat++;
    if (bus.rf_we) wr_cnt++;
    if (bus.done) begin
      done_cnt++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pulse");
      end else begin
        cur = sbq.pop_front();
        check("illegal", 32'(bus.illegal), 32'(cur.ill));
        check("solved",  32'(bus.solved),  32'(cur.sol));
        check("latency", lat, cur.lat);
        check("writes",  wr_cnt, cur.writes);
        check("board",   32'(rf[0]), 32'(cur.board));
        check("count",   32'(rf[1]), 32'(cur.cnt));
        check("log",     32'(rf[2]), 32'(cur.ord));
      end
    end
  end

  task automatic preload(input logic [17:0] b, input logic [17:0] c, input logic [17:0] o);
    @(negedge clk); pl_en = 1'b1; pl_addr = 4'd0; pl_data = b;
    @(negedge clk); pl_addr = 4'd1; pl_data = c;
    @(negedge clk); pl_addr = 4'd2; pl_data = o;
    @(negedge clk); pl_en = 1'b0;
  endtask

  task automatic push_exp(input logic [17:0] b, input logic [17:0] c, input logic [17:0] o,
                          input logic ill, input logic sol);
    exp_t e;
    e.board = b; e.cnt = c; e.ord = o; e.ill = ill; e.sol = sol;
    e.lat = ill ? 4 : 7;
    e.writes = ill ? 0 : 3;
    sbq.push_back(e);
  endtask

  task automatic accept_cmd(input logic [1:0] d, input bit keep_valid);
    int a0;
    int k;
    a0 = acc_cnt;
    k = 0;
    @(negedge clk);
    bus.mv_valid = 1'b1;
    bus.mv_dir = d;
    while (acc_cnt == a0 && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    if (!keep_valid) bus.mv_valid = 1'b0;
    checks++;
    if (acc_cnt == a0) begin
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept within 30 cycles");
    end
  endtask

  task automatic wait_done(input int d0);
    int k;
    k = 0;
    while (done_cnt == d0 && k < 30) begin
      @(negedge clk); #1;
      k++;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL done_timeout: got no done expected done within 30 cycles");
    end
  endtask

  task automatic run_vec(input vec_t v);
    int d0;
    preload(v.board, v.cnt, v.ord);
    push_exp(v.e_board, v.e_cnt, v.e_ord, v.e_ill, v.e_sol);
    d0 = done_cnt;
    accept_cmd(v.dir, 1'b0);
    wait_done(d0);
  endtask

  initial begin
    logic [17:0] ord_m;
    int d0;
    int a0;
    int k;

    vt[0]  = '{18'h0A728, 18'h00000, 18'h00000, 2'd0, 18'h0A12B, 18'h00001, 18'h00000, 1'b0, 1'b0};
    vt[1]  = '{18'h0A12B, 18'h00001, 18'h00000, 2'd1, 18'h0A728, 18'h00002, 18'h00001, 1'b0, 1'b1};
    vt[2]  = '{18'h0A728, 18'h00000, 18'h00000, 2'd3, 18'h0A728, 18'h00000, 18'h00000, 1'b1, 1'b1};
    vt[3]  = '{18'h0A728, 18'h00000, 18'h00000, 2'd2, 18'h0A705, 18'h00001, 18'h00002, 1'b0, 1'b0};
    vt[4]  = '{18'h0A728, 18'h3FFFF, 18'h00000, 2'd0, 18'h0A12B, 18'h3FFFF, 18'h00000, 1'b0, 1'b0};
    vt[5]  = '{18'h0A728, 18'h00007, 18'h00005, 2'd1, 18'h0A728, 18'h00007, 18'h00005, 1'b1, 1'b1};
    vt[6]  = '{18'h0A729, 18'h00000, 18'h00000, 2'd0, 18'h0A729, 18'h00000, 18'h00000, 1'b1, 1'b0};
    vt[7]  = '{18'h014E5, 18'h00000, 18'h00000, 2'd2, 18'h014E5, 18'h00000, 18'h00000, 1'b1, 1'b0};
    vt[8]  = '{18'h014E5, 18'h00005, 18'h12345, 2'd3, 18'h084E5, 18'h00006, 18'h08D17, 1'b0, 1'b0};
    vt[9]  = '{18'h014E5, 18'h3FFFE, 18'h3FFFF, 2'd1, 18'h19425, 18'h3FFFF, 18'h3FFFD, 1'b0, 1'b0};
    vt[10] = '{18'h014E5, 18'h00000, 18'h00000, 2'd0, 18'h014E5, 18'h00000, 18'h00000, 1'b1, 1'b0};
    vt[11] = '{18'h08425, 18'h00000, 18'h00000, 2'd1, 18'h0C405, 18'h00001, 18'h00001, 1'b0, 1'b0};

    rst = 1'b1;
    bus.mv_valid = 1'b0;
    bus.mv_dir = 2'd0;
    pl_en = 1'b0;
    pl_addr = 4'd0;
    pl_data = 18'h0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready",   32'(bus.mv_ready), 32'd0);
    check("rst_we",      32'(bus.rf_we),    32'd0);
    check("rst_done",    32'(bus.done),     32'd0);
    check("rst_illegal", 32'(bus.illegal),  32'd0);
    check("rst_solved",  32'(bus.solved),   32'd0);
    check("rst_src0",    32'(bus.rf_src0),  32'd0);
    check("rst_src1",    32'(bus.rf_src1),  32'd0);
    check("rst_dst",     32'(bus.rf_dst),   32'd0);
    check("rst_wdata",   32'(bus.rf_wdata), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_rst", 32'(bus.mv_ready), 32'd1);

    for (int i = 0; i < 12; i++) run_vec(vt[i]);

    // Ten legal moves: the log keeps only the last nine directions.
    preload(18'h0A728, 18'h00000, 18'h3FFFF);
    ord_m = 18'h3FFFF;
    for (int i = 0; i < 10; i++) begin
      ord_m = {ord_m[15:0], 2'(i % 2)};
      push_exp((i % 2 == 0) ? 18'h0A12B : 18'h0A728, 18'(i + 1), ord_m, 1'b0, (i % 2 == 1));
      d0 = done_cnt;
      accept_cmd(2'(i % 2), 1'b0);
      wait_done(d0);
    end
    check("log_last9", 32'(rf[2]), 32'h11111);

    // Reset while the count write is on the bus.
    preload(18'h0A728, 18'h00000, 18'h00000);
    d0 = done_cnt;
    accept_cmd(2'd0, 1'b0);
    k = 0;
    while (!(bus.rf_we && bus.rf_dst == 4'd1) && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("saw_count_write", 32'(bus.rf_we && bus.rf_dst == 4'd1), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_ready", 32'(bus.mv_ready), 32'd1);
    repeat (10) @(negedge clk);
    check("mid_rst_board", 32'(rf[0]), 32'h0A12B);
    check("mid_rst_count", 32'(rf[1]), 32'h00000);
    check("mid_rst_log",   32'(rf[2]), 32'h00000);
    check("mid_rst_nodone", done_cnt, d0);

    // mv_valid held high through a busy command: exactly one accept.
    preload(18'h0A728, 18'h00000, 18'h00000);
    push_exp(18'h0A12B, 18'h00001, 18'h00000, 1'b0, 1'b0);
    d0 = done_cnt;
    a0 = acc_cnt;
    accept_cmd(2'd0, 1'b1);
    repeat (7) @(posedge clk);
    #1 bus.mv_valid = 1'b0;
    check("held_valid_accepts", acc_cnt, a0 + 1);
    wait_done(d0);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
